// File: rtl/seq_slot_table.sv
// Slot descriptor register file for bank1: host write/readback, sequencer
// descriptor fetch and status update, and a cycle profiler that commits into the profile field.
module seq_slot_table #(
  parameter int INDEX_WIDTH    = 3,
  parameter int SRC_ADDR_WIDTH = 32,
  parameter int SRC_SIZE_WIDTH = 26,
  parameter int DST_ADDR_WIDTH = 32,
  parameter int DST_SIZE_WIDTH = 26,
  parameter int STATUS_WIDTH   = 2,
  parameter int PROFILE_WIDTH  = 32,
  parameter int LD_MSK_WIDTH   = 8,
  parameter int ST_MSK_WIDTH   = 8,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [INDEX_WIDTH-1:0]    wr_index,
  input  logic [SRC_ADDR_WIDTH-1:0] wr_src_addr,
  input  logic [SRC_SIZE_WIDTH-1:0] wr_src_size,
  input  logic [DST_ADDR_WIDTH-1:0] wr_des_addr,
  input  logic [DST_SIZE_WIDTH-1:0] wr_des_size,
  input  logic [STATUS_WIDTH-1:0]   wr_status,
  input  logic [PROFILE_WIDTH-1:0]  wr_profile,
  input  logic [LD_MSK_WIDTH-1:0]   wr_ld_mask,
  input  logic [ST_MSK_WIDTH-1:0]   wr_st_mask,
  input  logic [ST_MSK_WIDTH-1:0]   wr_st_intr_mask_abs,
  input  logic                      set_src_addr,
  input  logic                      set_src_size,
  input  logic                      set_des_addr,
  input  logic                      set_des_size,
  input  logic                      set_status,
  input  logic                      set_profile,
  input  logic                      set_ld_mask,
  input  logic                      set_st_mask,
  input  logic                      set_st_intr_mask_abs,
  input  logic                      rd_req,
  input  logic [INDEX_WIDTH-1:0]    rd_index,
  input  logic [3:0]                rd_field,
  output logic                      rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      seq_req,
  input  logic [INDEX_WIDTH-1:0]    seq_index,
  output logic                      seq_valid,
  output logic [SRC_ADDR_WIDTH-1:0] seq_src_addr,
  output logic [SRC_SIZE_WIDTH-1:0] seq_src_size,
  output logic [DST_ADDR_WIDTH-1:0] seq_des_addr,
  output logic [DST_SIZE_WIDTH-1:0] seq_des_size,
  output logic [LD_MSK_WIDTH-1:0]   seq_ld_mask,
  output logic [ST_MSK_WIDTH-1:0]   seq_st_mask,
  output logic [ST_MSK_WIDTH-1:0]   seq_st_intr_mask_abs,
  input  logic                      seq_status_set,
  input  logic [STATUS_WIDTH-1:0]   seq_status_in,
  input  logic                      prof_start,
  input  logic                      prof_stop,
  output logic                      prof_busy
);

  localparam int ROWS = 2 ** INDEX_WIDTH;

  typedef enum logic {IDLE, RUN} prof_state_e;

  logic [SRC_ADDR_WIDTH-1:0] src_addr_q [ROWS], src_addr_d [ROWS];
  logic [SRC_SIZE_WIDTH-1:0] src_size_q [ROWS], src_size_d [ROWS];
  logic [DST_ADDR_WIDTH-1:0] des_addr_q [ROWS], des_addr_d [ROWS];
  logic [DST_SIZE_WIDTH-1:0] des_size_q [ROWS], des_size_d [ROWS];
  logic [STATUS_WIDTH-1:0]   status_q   [ROWS], status_d   [ROWS];
  logic [PROFILE_WIDTH-1:0]  profile_q  [ROWS], profile_d  [ROWS];
  logic [LD_MSK_WIDTH-1:0]   ld_mask_q  [ROWS], ld_mask_d  [ROWS];
  logic [ST_MSK_WIDTH-1:0]   st_mask_q  [ROWS], st_mask_d  [ROWS];
  logic [ST_MSK_WIDTH-1:0]   st_intr_q  [ROWS], st_intr_d  [ROWS];

  prof_state_e              state_q, state_d;
  logic [PROFILE_WIDTH-1:0] count_q, count_d, count_inc;
  logic [INDEX_WIDTH-1:0]   row_q, row_d;
  logic                     commit;

  logic                      rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
  logic                      seq_valid_q, seq_valid_d;
  logic [SRC_ADDR_WIDTH-1:0] seq_src_addr_q, seq_src_addr_d;
  logic [SRC_SIZE_WIDTH-1:0] seq_src_size_q, seq_src_size_d;
  logic [DST_ADDR_WIDTH-1:0] seq_des_addr_q, seq_des_addr_d;
  logic [DST_SIZE_WIDTH-1:0] seq_des_size_q, seq_des_size_d;
  logic [LD_MSK_WIDTH-1:0]   seq_ld_mask_q, seq_ld_mask_d;
  logic [ST_MSK_WIDTH-1:0]   seq_st_mask_q, seq_st_mask_d;
  logic [ST_MSK_WIDTH-1:0]   seq_st_intr_q, seq_st_intr_d;

  // Saturating increment doubles as the committed value (count + 1).
  always_comb begin
    count_inc = (count_q == '1) ? count_q : count_q + PROFILE_WIDTH'(1);
    state_d   = state_q;
    count_d   = count_q;
    row_d     = row_q;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (prof_start) begin
          state_d = RUN;
          row_d   = seq_index;
          count_d = '0;
        end
      end
      RUN: begin
        count_d = count_inc;
        if (prof_stop) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
        if (prof_start) begin
          state_d = RUN;
          row_d   = seq_index;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Priority is ordered by assignment: host, then sequencer status, then profiler commit.
  always_comb begin
    src_addr_d = src_addr_q;
    src_size_d = src_size_q;
    des_addr_d = des_addr_q;
    des_size_d = des_size_q;
    status_d   = status_q;
    profile_d  = profile_q;
    ld_mask_d  = ld_mask_q;
    st_mask_d  = st_mask_q;
    st_intr_d  = st_intr_q;
    if (set_src_addr)         src_addr_d[wr_index] = wr_src_addr;
    if (set_src_size)         src_size_d[wr_index] = wr_src_size;
    if (set_des_addr)         des_addr_d[wr_index] = wr_des_addr;
    if (set_des_size)         des_size_d[wr_index] = wr_des_size;
    if (set_status)           status_d[wr_index]   = wr_status;
    if (set_profile)          profile_d[wr_index]  = wr_profile;
    if (set_ld_mask)          ld_mask_d[wr_index]  = wr_ld_mask;
    if (set_st_mask)          st_mask_d[wr_index]  = wr_st_mask;
    if (set_st_intr_mask_abs) st_intr_d[wr_index]  = wr_st_intr_mask_abs;
    if (seq_status_set)       status_d[seq_index]  = seq_status_in;
    if (commit)               profile_d[row_q]     = count_inc;
  end

  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = '0;
    if (rd_req) begin
      case (rd_field)
        4'd0:    rd_data_d = DATA_WIDTH'(src_addr_q[rd_index]);
        4'd1:    rd_data_d = DATA_WIDTH'(src_size_q[rd_index]);
        4'd2:    rd_data_d = DATA_WIDTH'(des_addr_q[rd_index]);
        4'd3:    rd_data_d = DATA_WIDTH'(des_size_q[rd_index]);
        4'd4:    rd_data_d = DATA_WIDTH'(status_q[rd_index]);
        4'd5:    rd_data_d = DATA_WIDTH'(profile_q[rd_index]);
        4'd6:    rd_data_d = DATA_WIDTH'(ld_mask_q[rd_index]);
        4'd7:    rd_data_d = DATA_WIDTH'(st_mask_q[rd_index]);
        4'd8:    rd_data_d = DATA_WIDTH'(st_intr_q[rd_index]);
        default: rd_data_d = '0;
      endcase
    end
    seq_valid_d    = seq_req;
    seq_src_addr_d = seq_src_addr_q;
    seq_src_size_d = seq_src_size_q;
    seq_des_addr_d = seq_des_addr_q;
    seq_des_size_d = seq_des_size_q;
    seq_ld_mask_d  = seq_ld_mask_q;
    seq_st_mask_d  = seq_st_mask_q;
    seq_st_intr_d  = seq_st_intr_q;
    if (seq_req) begin
      seq_src_addr_d = src_addr_q[seq_index];
      seq_src_size_d = src_size_q[seq_index];
      seq_des_addr_d = des_addr_q[seq_index];
      seq_des_size_d = des_size_q[seq_index];
      seq_ld_mask_d  = ld_mask_q[seq_index];
      seq_st_mask_d  = st_mask_q[seq_index];
      seq_st_intr_d  = st_intr_q[seq_index];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROWS; i++) begin
        src_addr_q[i] <= '0;
        src_size_q[i] <= '0;
        des_addr_q[i] <= '0;
        des_size_q[i] <= '0;
        status_q[i]   <= '0;
        profile_q[i]  <= '0;
        ld_mask_q[i]  <= '0;
        st_mask_q[i]  <= '0;
        st_intr_q[i]  <= '0;
      end
      state_q        <= IDLE;
      count_q        <= '0;
      row_q          <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      seq_valid_q    <= 1'b0;
      seq_src_addr_q <= '0;
      seq_src_size_q <= '0;
      seq_des_addr_q <= '0;
      seq_des_size_q <= '0;
      seq_ld_mask_q  <= '0;
      seq_st_mask_q  <= '0;
      seq_st_intr_q  <= '0;
    end else begin
      src_addr_q     <= src_addr_d;
      src_size_q     <= src_size_d;
      des_addr_q     <= des_addr_d;
      des_size_q     <= des_size_d;
      status_q       <= status_d;
      profile_q      <= profile_d;
      ld_mask_q      <= ld_mask_d;
      st_mask_q      <= st_mask_d;
      st_intr_q      <= st_intr_d;
      state_q        <= state_d;
      count_q        <= count_d;
      row_q          <= row_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      seq_valid_q    <= seq_valid_d;
      seq_src_addr_q <= seq_src_addr_d;
      seq_src_size_q <= seq_src_size_d;
      seq_des_addr_q <= seq_des_addr_d;
      seq_des_size_q <= seq_des_size_d;
      seq_ld_mask_q  <= seq_ld_mask_d;
      seq_st_mask_q  <= seq_st_mask_d;
      seq_st_intr_q  <= seq_st_intr_d;
    end
  end

  assign rd_valid             = rd_valid_q;
  assign rd_data              = rd_data_q;
  assign seq_valid            = seq_valid_q;
  assign seq_src_addr         = seq_src_addr_q;
  assign seq_src_size         = seq_src_size_q;
  assign seq_des_addr         = seq_des_addr_q;
  assign seq_des_size         = seq_des_size_q;
  assign seq_ld_mask          = seq_ld_mask_q;
  assign seq_st_mask          = seq_st_mask_q;
  assign seq_st_intr_mask_abs = seq_st_intr_q;
  assign prof_busy            = (state_q == RUN);

endmodule

// File: doc/seq_slot_table.md
Name: seq_slot_table

Overview:
- Bank1 slot table storage: the register file that consumes the bank1 write strobes and data produced by the AXI-lite write decoder.
- Holds one descriptor row per sequencer slot: src/dst address and size, status, profile, load/store masks, store-interrupt mask.
- Serves three clients: host readback for the AXI-lite read path, descriptor fetch for the sequencer engine, and a cycle profiler that writes elapsed cycles into the profile field.

Parameters:
INDEX_WIDTH, 3, slot index width; 2^INDEX_WIDTH rows
SRC_ADDR_WIDTH, 32, source address field width
SRC_SIZE_WIDTH, 26, source size field width
DST_ADDR_WIDTH, 32, destination address field width
DST_SIZE_WIDTH, 26, destination size field width
STATUS_WIDTH, 2, status field width
PROFILE_WIDTH, 32, profile field and profile counter width
LD_MSK_WIDTH, 8, load mask width
ST_MSK_WIDTH, 8, store mask and store-interrupt mask width
DATA_WIDTH, 32, host readback width; every field is <= DATA_WIDTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
wr_index  in  INDEX_WIDTH  host write row
wr_src_addr/wr_src_size/wr_des_addr/wr_des_size/wr_status/wr_profile/wr_ld_mask/wr_st_mask/wr_st_intr_mask_abs  in  field widths  host write data, one per field
set_src_addr/set_src_size/set_des_addr/set_des_size/set_status/set_profile/set_ld_mask/set_st_mask/set_st_intr_mask_abs  in  1 each  single-cycle host write strobes, at most one high per cycle
rd_req  in  1  host read request
rd_index  in  INDEX_WIDTH  host read row
rd_field  in  4  field select: 0 src_addr, 1 src_size, 2 des_addr, 3 des_size, 4 status, 5 profile, 6 ld_mask, 7 st_mask, 8 st_intr_mask_abs
rd_valid  out  1  host read data valid
rd_data  out  DATA_WIDTH  host read data, zero-extended
seq_req  in  1  sequencer descriptor fetch request
seq_index  in  INDEX_WIDTH  sequencer row
seq_valid  out  1  descriptor valid
seq_src_addr/seq_src_size/seq_des_addr/seq_des_size/seq_ld_mask/seq_st_mask/seq_st_intr_mask_abs  out  field widths  fetched descriptor
seq_status_set  in  1  sequencer status write strobe
seq_status_in  in  STATUS_WIDTH  sequencer status value, written to row seq_index
prof_start  in  1  arm the profiler on row seq_index
prof_stop  in  1  commit the profile count and disarm
prof_busy  out  1  profiler armed

Behaviour:
- Reset (reset low, asynchronous): every table field 0; rd_valid, rd_data, seq_valid and all seq_* data outputs 0; profiler disarmed, counter 0, latched row 0; prof_busy 0.
- Host write: when set_X is high at a rising edge, field X of row wr_index takes wr_X. The new value is visible to reads issued in the next cycle.
- Host read: rd_req high at edge N gives rd_valid=1 and rd_data=field(rd_index, rd_field) zero-extended, valid for exactly cycle N+1.
  - Read-before-write: a same-cycle write to the same row and field returns the old value.
  - rd_field 9..15 returns 0 with rd_valid=1.
  - Back-to-back rd_req is accepted every cycle, no stall.
- Sequencer fetch: seq_req at edge N gives seq_valid=1 for cycle N+1, with all seq_* fields of row seq_index captured at edge N (read-before-write). seq_* outputs hold their value until the next seq_req.
- Status collision: seq_status_set and set_status on the same row in the same cycle resolve to the sequencer value. On different rows, both writes take effect.
- Profiler states: IDLE and RUN.
  - IDLE -> RUN on prof_start: latch seq_index, clear the counter to 0.
  - In RUN, the counter increments by 1 each cycle and saturates at all-ones (no wrap).
  - RUN -> IDLE on prof_stop: write the counter value plus 1 (saturating) into profile[latched row], so start at edge N and stop at edge N+k stores k.
  - prof_start while in RUN: restart on the new seq_index, discarding the old count without a commit.
  - prof_start and prof_stop in the same cycle in RUN: commit the old row, then rearm on the new row with the counter cleared.
  - prof_stop in IDLE is ignored.
  - A profiler commit and a same-cycle host set_profile on the same row resolve to the profiler value.
  - prof_busy = (state == RUN).
- Reset asserted mid-operation returns every state and field to its reset value; no partial commit.

Test Plan:
- Reset then read all 8 rows x 9 fields -> every rd_data = 0, rd_valid exactly 1 cycle after each rd_req.
- set_src_addr row 5 with 0xDEADBEEF; set_src_size row 5 with 0x3FFFFFF; read both the next cycle -> 0xDEADBEEF and 0x03FFFFFF. Row 4 still reads 0.
- Write status row 2 = 1 with rd_req on the same row/field in the same cycle -> read returns 0; a repeat read returns 1.
- Same cycle: set_status row 3 = 2 and seq_status_set row 3 = 3 -> status reads 3. Same case with seq on row 4 -> row 3 = 2, row 4 = 3.
- prof_start on row 1, prof_stop 100 cycles later -> profile[1] = 100, prof_busy high for 100 cycles. prof_start row 6 while running, stop 10 cycles later -> profile[1] unchanged, profile[6] = 10.
- seq_req row 5 after the writes above -> seq_valid 1 cycle later, seq_src_addr = 0xDEADBEEF. Assert reset mid-RUN -> prof_busy 0, all fields 0.
